// File: rtl/xgmii_rx_link_fault_pkg.sv
// Shared constants and encodings for the XGMII receive link fault stage.
// Holds the XGMII control characters, the fault sequence codes and the link/FSM encodings.
package xgmii_rx_link_fault_pkg;

  localparam logic [7:0]  XGMII_IDLE = 8'h07;
  localparam logic [7:0]  XGMII_SEQ  = 8'h9C;

  // Bytes 1..3 of a sequence column as they appear on bits [31:8].
  localparam logic [23:0] LF_CODE    = 24'h010000;
  localparam logic [23:0] RF_CODE    = 24'h020000;

  localparam logic [63:0] IDLE_WORD  = {8{XGMII_IDLE}};
  localparam logic [7:0]  IDLE_CTRL  = 8'hFF;

  typedef enum logic [1:0] {
    LINK_OK = 2'b00,
    LINK_LF = 2'b01,
    LINK_RF = 2'b10
  } link_code_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_COUNT = 2'b01,
    ST_FAULT = 2'b10
  } lf_state_e;

endpackage

// File: rtl/xgmii_seq_col_decode.sv
// Combinational classifier for one 32-bit XGMII column: reports whether the
// column carries a Local Fault, a Remote Fault or no fault sequence.
module xgmii_seq_col_decode
  import xgmii_rx_link_fault_pkg::*;
(
  input  logic [31:0] col_data,
  input  logic [3:0]  col_ctrl,
  output link_code_e  col_type
);

  // Only a control character in lane 0 of the column with data bytes in lanes 1..3
  // qualifies; any other 0x9C column counts as an ordinary column.
  always_comb begin
    col_type = LINK_OK;
    if ((col_ctrl == 4'b0001) && (col_data[7:0] == XGMII_SEQ)) begin
      if (col_data[31:8] == LF_CODE) begin
        col_type = LINK_LF;
      end else if (col_data[31:8] == RF_CODE) begin
        col_type = LINK_RF;
      end
    end
  end

endmodule

// File: rtl/xgmii_rx_link_fault.sv
// Receive link fault detection and Idle substitution for a 64-bit XGMII stream.
// Defining XGMII_RX_LINK_FAULT_STATS_EN adds saturating LF/RF event counters.
module xgmii_rx_link_fault
  import xgmii_rx_link_fault_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int COL_WINDOW    = 128,
  parameter int SEQ_THRESHOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] xgmii_rxd_in,
  input  logic [CTRL_WIDTH-1:0] xgmii_rxc_in,
  output logic [DATA_WIDTH-1:0] xgmii_rxd_out,
  output logic [CTRL_WIDTH-1:0] xgmii_rxc_out,
  output logic [1:0]            link_fault,
  output logic                  fault_seq_det,
`ifdef XGMII_RX_LINK_FAULT_STATS_EN
  output logic [15:0]           lf_event_count,
  output logic [15:0]           rf_event_count,
`endif
  output lf_state_e             dbg_state
);

  localparam int COL_W = $clog2(COL_WINDOW) + 1;
  localparam int SEQ_W = $clog2(SEQ_THRESHOLD) + 1;
  localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(COL_WINDOW);
  localparam logic [SEQ_W-1:0] SEQ_LIMIT = SEQ_W'(SEQ_THRESHOLD);

  generate
    if (DATA_WIDTH != 64) begin : g_bad_width
      $fatal(1, "xgmii_rx_link_fault: DATA_WIDTH must be 64");
    end
  endgenerate

  typedef struct packed {
    lf_state_e              state;
    link_code_e             seq_type;
    logic [SEQ_W-1:0]       seq_cnt;
    logic [COL_W-1:0]       col_cnt;
    link_code_e             link;
  } lf_ctx_t;

  localparam lf_ctx_t CTX_RESET = '{ST_INIT, LINK_OK, SEQ_W'(0), COL_W'(0), LINK_OK};

  link_code_e col0_type;
  link_code_e col1_type;
  lf_ctx_t    ctx_q;
  lf_ctx_t    ctx_mid;
  lf_ctx_t    ctx_nxt;

  logic [DATA_WIDTH-1:0] rxd_nxt;
  logic [CTRL_WIDTH-1:0] rxc_nxt;
  logic                  seq_det_nxt;

  xgmii_seq_col_decode u_col0_decode (
    .col_data (xgmii_rxd_in[31:0]),
    .col_ctrl (xgmii_rxc_in[3:0]),
    .col_type (col0_type)
  );

  xgmii_seq_col_decode u_col1_decode (
    .col_data (xgmii_rxd_in[63:32]),
    .col_ctrl (xgmii_rxc_in[7:4]),
    .col_type (col1_type)
  );

  // Advances the whole fault context by a single column. Applied twice per
  // word so that two sequences in one word are counted separately.
  function automatic lf_ctx_t col_step(input lf_ctx_t c, input link_code_e t);
    lf_ctx_t n;
    n = c;
    if (t == LINK_OK) begin
      if (c.col_cnt < COL_LIMIT) begin
        n.col_cnt = c.col_cnt + 1'b1;
      end
      if (n.col_cnt == COL_LIMIT) begin
        if (c.link != LINK_OK) begin
          n.link     = LINK_OK;
          n.state    = ST_INIT;
          n.seq_type = LINK_OK;
          n.seq_cnt  = '0;
        end else if (c.state == ST_COUNT) begin
          n.state   = ST_INIT;
          n.seq_cnt = '0;
        end
      end
    end else begin
      n.col_cnt = '0;
      case (c.state)
        ST_INIT: begin
          n.seq_type = t;
          n.seq_cnt  = SEQ_W'(1);
          n.state    = ST_COUNT;
        end
        ST_COUNT: begin
          if (t == c.seq_type) begin
            if (c.seq_cnt < SEQ_LIMIT) begin
              n.seq_cnt = c.seq_cnt + 1'b1;
            end
            if (n.seq_cnt == SEQ_LIMIT) begin
              n.link  = t;
              n.state = ST_FAULT;
            end
          end else begin
            n.seq_type = t;
            n.seq_cnt  = SEQ_W'(1);
          end
        end
        ST_FAULT: begin
          // A new fault type must earn its own threshold; link keeps the old code meanwhile.
          if (t != c.seq_type) begin
            n.state    = ST_COUNT;
            n.seq_type = t;
            n.seq_cnt  = SEQ_W'(1);
          end
        end
        default: begin
          n.state   = ST_INIT;
          n.seq_cnt = '0;
        end
      endcase
    end
    return n;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx_q <= CTX_RESET;
    end else begin
      ctx_q <= ctx_nxt;
    end
  end

  // Next-state: column 0 is processed before column 4
  always_comb begin
    ctx_mid = col_step(ctx_q, col0_type);
    ctx_nxt = col_step(ctx_mid, col1_type);
  end

  // Output decode: the word that completes the threshold already leaves as Idle
  always_comb begin
    rxd_nxt     = xgmii_rxd_in;
    rxc_nxt     = xgmii_rxc_in;
    seq_det_nxt = (col0_type != LINK_OK) || (col1_type != LINK_OK);
    if (ctx_nxt.link != LINK_OK) begin
      rxd_nxt = IDLE_WORD;
      rxc_nxt = IDLE_CTRL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xgmii_rxd_out <= IDLE_WORD;
      xgmii_rxc_out <= IDLE_CTRL;
      fault_seq_det <= 1'b0;
    end else begin
      xgmii_rxd_out <= rxd_nxt;
      xgmii_rxc_out <= rxc_nxt;
      fault_seq_det <= seq_det_nxt;
    end
  end

  assign link_fault = ctx_q.link;
  assign dbg_state  = ctx_q.state;

`ifdef XGMII_RX_LINK_FAULT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lf_event_count <= 16'd0;
      rf_event_count <= 16'd0;
    end else if (ctx_nxt.link != ctx_q.link) begin
      if ((ctx_nxt.link == LINK_LF) && (lf_event_count != 16'hFFFF)) begin
        lf_event_count <= lf_event_count + 16'd1;
      end
      if ((ctx_nxt.link == LINK_RF) && (rf_event_count != 16'hFFFF)) begin
        rf_event_count <= rf_event_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_xgmii_rx_link_fault.sv
// Bench for xgmii_rx_link_fault: directed link fault scenarios followed by
// randomized column mixes, checked against a run-length reference model.
module tb_xgmii_rx_link_fault;
  import xgmii_rx_link_fault_pkg::*;

  localparam int COL_WINDOW    = 128;
  localparam int SEQ_THRESHOLD = 4;
  localparam logic [63:0] IDLE64 = 64'h0707070707070707;

  logic        clk;
  logic        rst_n;
  logic [63:0] xgmii_rxd_in;
  logic [7:0]  xgmii_rxc_in;
  logic [63:0] xgmii_rxd_out;
  logic [7:0]  xgmii_rxc_out;
  logic [1:0]  link_fault;
  logic        fault_seq_det;
  lf_state_e   dbg_state;
`ifdef XGMII_RX_LINK_FAULT_STATS_EN
  logic [15:0] lf_event_count;
  logic [15:0] rf_event_count;
`endif

  xgmii_rx_link_fault #(
    .DATA_WIDTH    (64),
    .COL_WINDOW    (COL_WINDOW),
    .SEQ_THRESHOLD (SEQ_THRESHOLD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .xgmii_rxd_in  (xgmii_rxd_in),
    .xgmii_rxc_in  (xgmii_rxc_in),
    .xgmii_rxd_out (xgmii_rxd_out),
    .xgmii_rxc_out (xgmii_rxc_out),
    .link_fault    (link_fault),
    .fault_seq_det (fault_seq_det),
`ifdef XGMII_RX_LINK_FAULT_STATS_EN
    .lf_event_count(lf_event_count),
    .rf_event_count(rf_event_count),
`endif
    .dbg_state     (dbg_state)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Scoreboard: {rxd, rxc, link, det} expected one cycle after each word
  logic [74:0] exp_q[$];

  // Reference model: run length of consecutive same-type sequences and
  // the number of plain columns seen since the last sequence.
  int m_gap;
  int m_run_type;
  int m_run_len;
  int m_status;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int col_kind(input logic [31:0] d, input logic [3:0] c);
    if (c == 4'b0001 && d[7:0] == 8'h9C) begin
      if (d[31:8] == 24'h010000) return 1;
      if (d[31:8] == 24'h020000) return 2;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_gap      = 0;
    m_run_type = 0;
    m_run_len  = 0;
    m_status   = 0;
    exp_q.delete();
  endtask

  task automatic model_col(input int t);
    if (t == 0) begin
      if (m_gap < COL_WINDOW) m_gap++;
      if (m_gap == COL_WINDOW) begin
        m_run_len = 0;
        m_status  = 0;
      end
    end else begin
      m_gap = 0;
      if (m_run_len > 0 && t == m_run_type) begin
        if (m_run_len < SEQ_THRESHOLD) m_run_len++;
      end else begin
        m_run_type = t;
        m_run_len  = 1;
      end
      if (m_run_len == SEQ_THRESHOLD) m_status = t;
    end
  endtask

  task automatic model_word(input logic [63:0] d, input logic [7:0] c);
    int t0;
    int t1;
    logic [71:0] word;
    t0 = col_kind(d[31:0], c[3:0]);
    t1 = col_kind(d[63:32], c[7:4]);
    model_col(t0);
    model_col(t1);
    word = (m_status != 0) ? {IDLE64, 8'hFF} : {d, c};
    exp_q.push_back({word, 2'(m_status), (t0 != 0 || t1 != 0)});
  endtask

  // Driver: one word per cycle, outputs sampled 1 time unit after the edge
  task automatic drive_word(input logic [63:0] d, input logic [7:0] c);
    logic [74:0] e;
    @(negedge clk);
    xgmii_rxd_in = d;
    xgmii_rxc_in = c;
    model_word(d, c);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rxd_out", xgmii_rxd_out, e[74:11]);
    check("rxc_out", 64'(xgmii_rxc_out), 64'(e[10:3]));
    check("link_fault", 64'(link_fault), 64'(e[2:1]));
    check("fault_seq_det", 64'(fault_seq_det), 64'(e[0]));
  endtask

  // Column kinds: 0 idle, 1 LF, 2 RF, 3 non-fault 0x9C, 4 data, 5 random ctrl/data
  function automatic logic [35:0] mk_col(input int k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      1:       return {4'h1, 32'h0100009C};
      2:       return {4'h1, 32'h0200009C};
      3:       return {4'h1, 8'h03, r[15:0], 8'h9C};
      4:       return {4'h0, r};
      5:       return {4'($urandom_range(0, 15)), r};
      default: return {4'hF, 32'h07070707};
    endcase
  endfunction

  task automatic send(input int k0, input int k1);
    logic [35:0] a;
    logic [35:0] b;
    a = mk_col(k0);
    b = mk_col(k1);
    drive_word({b[31:0], a[31:0]}, {b[35:32], a[35:32]});
  endtask

  function automatic int pick_col(input int pfault, input int fav);
    int r;
    r = $urandom_range(0, 99);
    if (r < pfault) return ($urandom_range(0, 9) < 8) ? fav : 3 - fav;
    if (r < pfault + 3) return 3;
    return ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(4, 5);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rxd"}, xgmii_rxd_out, IDLE64);
    check({tag, "_rxc"}, 64'(xgmii_rxc_out), 64'hFF);
    check({tag, "_link"}, 64'(link_fault), 64'h0);
    check({tag, "_det"}, 64'(fault_seq_det), 64'h0);
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_INIT));
  endtask

  initial begin
    int pfault;
    int fav;
    total = 0;
    bad   = 0;
    model_reset();
    rst_n        = 1'b0;
    xgmii_rxd_in = IDLE64;
    xgmii_rxc_in = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle stream
    repeat (500) send(0, 0);

    // Sparse lane-0 LF sequences, one every 10 words
    for (int i = 0; i < 4; i++) begin
      send(1, 0);
      check("lf_declare", 64'(link_fault), (i == 3) ? 64'h1 : 64'h0);
      if (i < 3) repeat (9) send(0, 0);
    end

    // 128 plain columns clear the fault
    repeat (63) send(0, 0);
    check("lf_hold_63", 64'(link_fault), 64'h1);
    send(0, 0);
    check("lf_clear_64", 64'(link_fault), 64'h0);

    // Alternating types inside one word never build a run
    repeat (20) send(1, 2);
    check("mixed_no_fault", 64'(link_fault), 64'h0);

    // RF fault, then LF takes over after its own threshold
    repeat (4) send(2, 0);
    check("rf_declare", 64'(link_fault), 64'h2);
    for (int i = 0; i < 4; i++) begin
      send(1, 0);
      check("lf_over_rf", 64'(link_fault), (i == 3) ? 64'h1 : 64'h2);
      repeat (3) send(0, 0);
    end

    // Async reset in the middle of a count
    repeat (70) send(0, 0);
    repeat (3) send(1, 0);
    check("pre_rst_count", 64'(link_fault), 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    model_reset();
    xgmii_rxd_in = IDLE64;
    xgmii_rxc_in = 8'hFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(1, 0);
    check("post_rst_1", 64'(link_fault), 64'h0);
    send(1, 0);
    send(1, 0);
    check("post_rst_3", 64'(link_fault), 64'h0);
    send(1, 0);
    check("post_rst_4", 64'(link_fault), 64'h1);

    // Randomized segments of varying fault density
    for (int s = 0; s < 16; s++) begin
      case ($urandom_range(0, 2))
        0:       pfault = 0;
        1:       pfault = 3;
        default: pfault = 25;
      endcase
      fav = $urandom_range(1, 2);
      repeat (200) send(pick_col(pfault, fav), pick_col(pfault, fav));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
